// File: rtl/big_alu.sv
// Mantissa-width integer ALU with a multiply-by-repeated-addition datapath.
// The external controller drives the selects and load enables; result and completion are registered.
module big_alu #(
  parameter int unsigned WIDTH = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ALUOp,
  input  logic             sumOrMultiplication,
  input  logic             muxA,
  input  logic             muxB,
  input  logic             muxC,
  input  logic             loadRegA,
  input  logic             loadRegB,
  input  logic [WIDTH-1:0] valor1,
  input  logic [WIDTH-1:0] valor2,
  output logic [WIDTH-1:0] result,
  output logic             endMultiplication
);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_XOR = 4'b0100
  } alu_op_t;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] cnt;
  logic             done;

  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] start_a;
  logic [WIDTH-1:0] start_b;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] cnt_inc;

  always_comb begin
    op_b    = muxA ? valor2 : reg_a;
    alu_res = valor1 + op_b;
    case (alu_op_t'(ALUOp))
      OP_ADD:  alu_res = valor1 + op_b;
      OP_SUB:  alu_res = valor1 - op_b;
      OP_AND:  alu_res = valor1 & op_b;
      OP_OR:   alu_res = valor1 | op_b;
      OP_XOR:  alu_res = valor1 ^ op_b;
      default: alu_res = valor1 + op_b;
    endcase
    // A start without a fresh capture replays the previously stored operands.
    start_a = loadRegB ? valor1 : reg_a;
    start_b = loadRegB ? valor2 : reg_b;
    addend  = muxC ? reg_a : valor1;
    cnt_inc = cnt + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      reg_a <= '0;
      reg_b <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else if (!loadRegA) begin
      done <= 1'b0;
    end else if (sumOrMultiplication) begin
      acc  <= alu_res;
      cnt  <= '0;
      done <= 1'b0;
    end else if (!muxB) begin
      if (loadRegB) begin
        reg_a <= valor1;
        reg_b <= valor2;
      end
      if (start_b == '0) begin
        acc  <= '0;
        cnt  <= '0;
        done <= 1'b1;
      end else begin
        acc  <= start_a;
        cnt  <= WIDTH'(1);
        done <= (start_b == WIDTH'(1));
      end
    end else if (cnt < reg_b) begin
      acc  <= acc + addend;
      cnt  <= cnt_inc;
      done <= (cnt_inc == reg_b);
    end else begin
      done <= 1'b0;
    end
  end

  assign result            = acc;
  assign endMultiplication = done;

endmodule

// File: tb/tb_big_alu.sv
// Directed-vector bench for big_alu: each vector drives one clock edge and checks result/endMultiplication.
module tb_big_alu;

  localparam int unsigned WIDTH = 23;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       ALUOp;
  logic             sumOrMultiplication;
  logic             muxA;
  logic             muxB;
  logic             muxC;
  logic             loadRegA;
  logic             loadRegB;
  logic [WIDTH-1:0] valor1;
  logic [WIDTH-1:0] valor2;
  logic [WIDTH-1:0] result;
  logic             endMultiplication;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  big_alu #(.WIDTH(WIDTH)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ALUOp               (ALUOp),
    .sumOrMultiplication (sumOrMultiplication),
    .muxA                (muxA),
    .muxB                (muxB),
    .muxC                (muxC),
    .loadRegA            (loadRegA),
    .loadRegB            (loadRegB),
    .valor1              (valor1),
    .valor2              (valor2),
    .result              (result),
    .endMultiplication   (endMultiplication)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one vector, let one rising edge pass, then check the registered outputs.
  task automatic vec(input string tag, input logic rst, input logic sum, input logic [3:0] op,
                     input logic ma, input logic mb, input logic mc, input logic la, input logic lb,
                     input int unsigned v1, input int unsigned v2,
                     input int unsigned exp_r, input logic exp_e);
    rst_n = rst; sumOrMultiplication = sum; ALUOp = op;
    muxA = ma; muxB = mb; muxC = mc; loadRegA = la; loadRegB = lb;
    valor1 = WIDTH'(v1); valor2 = WIDTH'(v2);
    @(posedge clk);
    #1;
    check({tag, ".result"}, 32'(result), 32'(exp_r));
    check({tag, ".end"}, 32'(endMultiplication), 32'(exp_e));
  endtask

  initial begin
    rst_n = 1'b0;
    //   tag          rst sum op     mA mB mC lA lB  v1  v2   result   end
    vec("reset",      0,  0,  4'h0,  1, 0, 1, 1, 1, 123, 3,   0,       0);

    vec("m20x5.s",    1,  0,  4'h0,  0, 0, 1, 1, 1, 20,  5,   20,      0);
    vec("m20x5.i1",   1,  0,  4'h0,  0, 1, 1, 1, 0, 0,   0,   40,      0);
    vec("m20x5.i2",   1,  0,  4'h0,  0, 1, 1, 1, 0, 0,   0,   60,      0);
    vec("m20x5.i3",   1,  0,  4'h0,  0, 1, 1, 1, 0, 0,   0,   80,      0);
    vec("m20x5.i4",   1,  0,  4'h0,  0, 1, 1, 1, 0, 0,   0,   100,     1);
    vec("m20x5.i5",   1,  0,  4'h0,  0, 1, 1, 1, 0, 0,   0,   100,     0);
    vec("m20x5.hold", 1,  0,  4'h0,  0, 1, 1, 0, 0, 7,   7,   100,     0);

    vec("m20x0.s",    1,  0,  4'h0,  0, 0, 1, 1, 1, 20,  0,   0,       1);
    vec("m20x0.i",    1,  0,  4'h0,  0, 1, 1, 1, 0, 20,  0,   0,       0);

    vec("m40x1.s",    1,  0,  4'h0,  0, 0, 1, 1, 1, 40,  1,   40,      1);

    vec("add",        1,  1,  4'h0,  1, 0, 0, 1, 0, 20,  10,  30,      0);
    vec("sub",        1,  1,  4'h1,  1, 0, 0, 1, 0, 20,  10,  10,      0);
    vec("and",        1,  1,  4'h2,  1, 0, 0, 1, 0, 20,  10,  0,       0);
    vec("or",         1,  1,  4'h3,  1, 0, 0, 1, 0, 20,  9,   29,      0);
    vec("xor",        1,  1,  4'h4,  1, 0, 0, 1, 0, 20,  28,  8,       0);
    vec("op7_add",    1,  1,  4'h7,  1, 0, 0, 1, 0, 20,  10,  30,      0);
    vec("sub_wrap",   1,  1,  4'h1,  1, 0, 0, 1, 0, 5,   10,  32'h7FFFFB, 0);
    vec("add_regA",   1,  1,  4'h0,  0, 0, 0, 1, 0, 20,  999, 60,      0);

    vec("m3x3.s",     1,  0,  4'h0,  0, 0, 0, 1, 1, 3,   3,   3,       0);
    vec("m3x3.live1", 1,  0,  4'h0,  0, 1, 0, 1, 0, 10,  0,   13,      0);
    vec("m3x3.live2", 1,  0,  4'h0,  0, 1, 0, 1, 0, 1,   0,   14,      1);
    vec("reuse.s",    1,  0,  4'h0,  0, 0, 1, 1, 0, 99,  0,   3,       0);
    vec("reuse.i1",   1,  0,  4'h0,  0, 1, 1, 1, 0, 99,  0,   6,       0);
    vec("reuse.i2",   1,  0,  4'h0,  0, 1, 1, 1, 0, 99,  0,   9,       1);

    vec("m7x9.s",     1,  0,  4'h0,  0, 0, 1, 1, 1, 7,   9,   7,       0);
    vec("m7x9.i1",    1,  0,  4'h0,  0, 1, 1, 1, 0, 0,   0,   14,      0);
    vec("m7x9.i2",    1,  0,  4'h0,  0, 1, 1, 1, 0, 0,   0,   21,      0);
    vec("m7x9.i3",    1,  0,  4'h0,  0, 1, 1, 1, 0, 0,   0,   28,      0);
    vec("m7x9.rst",   0,  0,  4'h0,  0, 1, 1, 1, 0, 0,   0,   0,       0);
    vec("m7x9.post",  1,  0,  4'h0,  0, 1, 1, 1, 0, 5,   0,   0,       0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/big_alu.md
Name: big_alu

Overview:
- 23-bit integer ALU/multiplier block in the floating-point datapath (mantissa-width operands).
- Performs single-cycle add/logic operations, and multi-cycle multiplication by repeated addition under external control. The controller supplies mux selects, register load enables and the mode bit.
- Result is registered. A completion pulse flags the cycle in which a product becomes final.

Parameters:
- WIDTH, 23, operand/result width; all arithmetic is modulo 2^WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- ALUOp  in  4  operation select, add mode only
- sumOrMultiplication  in  1  mode: 1 = add/logic, 0 = multiply
- muxA  in  1  add-mode operand select (see Behaviour)
- muxB  in  1  multiply step select: 0 = start, 1 = iterate
- muxC  in  1  iterate addend select: 1 = stored multiplicand, 0 = live valor1
- loadRegA  in  1  enable for result/counter/done update
- loadRegB  in  1  enable for operand capture on a multiply start
- valor1  in  WIDTH  operand 1 / multiplicand
- valor2  in  WIDTH  operand 2 / multiplier
- result  out  WIDTH  registered result (accumulator)
- endMultiplication  out  1  registered one-cycle completion pulse

Behaviour:
- Internal registers: acc (drives result), regA (multiplicand), regB (multiplier), cnt (WIDTH-bit iteration count), done (drives endMultiplication).
- All updates occur on the rising edge of clk.
- Reset: rst_n=0 at a clock edge clears acc, regA, regB, cnt and done to 0. This takes priority over every other input, including mid-multiplication.
- Hold: loadRegA=0 (not in reset) holds acc, cnt, regA and regB, and forces done<=0. This applies in both modes.
- Add mode (sumOrMultiplication=1, loadRegA=1):
  - Operand B = valor2 when muxA=1, otherwise regA.
  - ALUOp 0000 ADD, 0001 SUB (valor1 - opB, two's complement wrap), 0010 AND, 0011 OR, 0100 XOR; any other code = ADD.
  - acc <= op result; done <= 0; cnt cleared to 0; regA/regB unchanged.
- Multiply start (sumOrMultiplication=0, muxB=0, loadRegA=1):
  - If loadRegB=1: regA <= valor1, regB <= valor2. If loadRegB=0: the previously captured regA/regB are used instead; in the items below, valor1/valor2 then mean regA/regB.
  - valor2=0: acc <= 0, cnt <= 0, done <= 1.
  - Otherwise: acc <= valor1, cnt <= 1, done <= (valor2==1).
  - muxA and ALUOp are ignored.
- Multiply iterate (sumOrMultiplication=0, muxB=1, loadRegA=1):
  - If cnt < regB: acc <= acc + addend, where addend = regA if muxC=1, else valor1. Also cnt <= cnt+1 and done <= (cnt+1 == regB).
  - If cnt >= regB (product already final): acc and cnt hold, done <= 0.
  - Consequence: done is high for exactly one cycle, in the cycle result first equals the product. Product valor1*valor2 is final after 1 start cycle plus (valor2-1) iterate cycles.
- Overflow: acc and cnt wrap modulo 2^WIDTH; no overflow flag.
- A start issued mid-multiplication abandons the current product and restarts with the new operands.
- Mode switch to add mid-multiplication overwrites acc and clears cnt.

Test Plan:
- Reset: rst_n=0 for one edge with arbitrary inputs -> result=0, endMultiplication=0.
- Multiply 20x5: start (v1=20, v2=5, loadRegA=loadRegB=1, muxC=1), then 4 iterate cycles -> result 20,40,60,80,100. endMultiplication=1 only on the 100 cycle. A further iterate cycle -> result 100, end=0. loadRegA=0 -> result 100, end=0.
- Multiply by zero: start v1=20, v2=0 -> result 0, end=1. A following iterate -> result 0, end=0.
- Multiply by one: start v1=40, v2=1 -> result 40, end=1 on the first cycle.
- Add/logic: sumOrMultiplication=1, muxA=1, v1=20, v2=10:
  - ALUOp 0000 -> 30, end=0.
  - ALUOp 0001 -> 10.
  - ALUOp 0010 -> 0.
  - v1=5, v2=10 with SUB -> 0x7FFFFB (wrap).
- Reset mid-multiply: start 7x9, 3 iterates, then rst_n=0 -> result 0, end=0. A subsequent iterate with regB=0 -> result holds 0.
